key_input_ctl: RTL and testbench
================================

Name: key_input_ctl

Overview:
- Input-side counterpart to the LED/seven-segment output path: conditions one raw push-button into clean control events.
- Synchronizes, debounces and classifies presses as short or long.
- Produces a registered direction bit for flash_led_ctl `dir` and a 4-bit press count for hex_seven_segment_decoder.
- Sits between the board button pin and the control logic in the top level.

Parameters:
- CYCLES_PER_SECOND, 100_000_000, clk frequency in Hz.
- DEBOUNCE_MS, 20, input must be stable this long to be accepted. DEBOUNCE_CYCLES = CYCLES_PER_SECOND/1000*DEBOUNCE_MS, must be >= 1.
- LONG_MS, 1000, hold time that qualifies a long press. LONG_CYCLES = CYCLES_PER_SECOND/1000*LONG_MS, must be > DEBOUNCE_CYCLES.
- ACTIVE_HIGH, 1, raw key polarity. 1 = pressed reads 1; 0 = pressed reads 0.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- key  input  1  raw asynchronous button pin.
- key_level  output  1  debounced pressed level.
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on accepted release.
- short_press  output  1  one-cycle strobe, coincident with release_pulse, when no long press fired during that hold.
- long_press  output  1  one-cycle strobe when the hold reaches LONG_CYCLES. Fires at most once per press.
- dir  output  1  direction bit; toggles on every long_press.
- press_cnt  output  4  count of accepted presses, wraps 15 -> 0.

Behaviour:
- Reset (rst = 0, asynchronous): every output is 0, FSM is IDLE, all counters are 0, synchronizer flops hold the released level (0 after polarity normalization).
- Normalization: k = key when ACTIVE_HIGH = 1, else ~key. k passes through a 2-flop synchronizer to give ks. All logic beyond this point uses ks only.
- Every output is driven by a register. There is no combinational path from key to any output.
- FSM state IDLE: when ks = 1, go to PRESS_WAIT and clear db_cnt.
- FSM state PRESS_WAIT:
  - ks = 0: return to IDLE. This is a bounce; no outputs change.
  - Otherwise increment db_cnt.
  - When db_cnt == DEBOUNCE_CYCLES-1 and ks = 1: go to PRESSED, clear hold_cnt and long_done.
  - In the same cycle register key_level = 1, press_pulse = 1 and press_cnt = press_cnt + 1 (4-bit modulo).
- FSM state PRESSED:
  - hold_cnt increments and saturates at LONG_CYCLES-1.
  - When hold_cnt == LONG_CYCLES-1 and long_done = 0: long_press = 1 for one cycle, dir = ~dir, long_done = 1.
  - ks = 0: go to RELEASE_WAIT and clear db_cnt.
- FSM state RELEASE_WAIT:
  - ks = 1: return to PRESSED. This is a release bounce: hold_cnt and long_done are kept, and no press_pulse is issued.
  - Otherwise increment db_cnt. At DEBOUNCE_CYCLES-1 go to IDLE.
  - In the same cycle register key_level = 0 and release_pulse = 1, plus short_press = ~long_done.
- hold_cnt also counts while in RELEASE_WAIT, so a long press can mature during a release bounce.
- Latency: a clean raw edge sampled at cycle 0 gives ks = 1 at cycle 2, PRESS_WAIT at cycle 3, and press_pulse / key_level high at cycle 3 + DEBOUNCE_CYCLES. Release timing is symmetric.
- Strobe width: each strobe is exactly one cycle. press_pulse and release_pulse never coincide.
- Any glitch shorter than DEBOUNCE_CYCLES in either direction produces no event.
- Wrap-around: press_cnt = 15 followed by a press gives 0.
- Boundary: with DEBOUNCE_CYCLES = 1, PRESS_WAIT lasts exactly one cycle.
- Reset asserted mid-press: all outputs and state return to reset values immediately. After rst deasserts with key still held, a fresh press is detected with full latency (another press_pulse).
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) and $clog2(LONG_CYCLES+1).

Decomposition:
- Shared header key_input_defs.vh holds:
  - the FSM state localparams IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT (2-bit encoding);
  - the DEBOUNCE_CYCLES and LONG_CYCLES derivation macros.
- Sub-module sync_2ff: 2-flop synchronizer with clk, rst (async active-low) and a reset value parameter. It is reusable for the other board inputs.

Test Plan (CYCLES_PER_SECOND = 1000, DEBOUNCE_MS = 4 -> 4 cycles, LONG_MS = 20 -> 20 cycles, ACTIVE_HIGH = 1):
1. Clean press held 10 cycles, then released -> press_pulse at cycle 7; key_level high cycles 7..17; release_pulse and short_press at cycle 17; dir stays 0; press_cnt = 1.
2. Bounce: key high 3 cycles, low 2, high 3, then low -> no strobes, key_level stays 0, press_cnt stays 0.
3. Long press: key held 30 cycles -> press_pulse at 7; long_press at cycle 27; dir = 1; on release, release_pulse = 1 and short_press = 0.
4. Release bounce: key held 12 cycles, low 2, high 5, then low -> exactly one press_pulse and one release_pulse; press_cnt = 1.
5. 16 clean short presses -> press_cnt returns to 0; 16 short_press strobes; dir unchanged.
6. rst driven low at cycle 10 of a held press, released at cycle 12, key still high -> all outputs 0 during reset; press_pulse at cycle 12 + 7 = 19; press_cnt = 1.

Source files
------------

// File: rtl/key_input_ctl_pkg.sv
// Shared definitions for the push-button conditioning path: FSM state
// encodings and the millisecond-to-cycle conversion used for timing parameters.
package key_input_ctl_pkg;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    // Divide first so large clock rates cannot overflow 32 bits.
    function automatic int unsigned ms_to_cycles(input int unsigned cycles_per_second,
                                                 input int unsigned ms);
        return cycles_per_second / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_input_ctl_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs. The reset value lets
// each input start at its own idle level.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the two stages into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_input_ctl.sv
// Push-button conditioner: synchronizes, debounces and classifies presses as
// short or long, and keeps a direction bit and a 4-bit press counter.
module key_input_ctl
    import key_input_ctl_pkg::*;
#(
    parameter int unsigned CYCLES_PER_SECOND = 100_000_000,
    parameter int unsigned DEBOUNCE_MS       = 20,
    parameter int unsigned LONG_MS           = 1000,
    parameter bit          ACTIVE_HIGH       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       dir,
    output logic [3:0] press_cnt
);

    localparam int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CYCLES_PER_SECOND, DEBOUNCE_MS);
    localparam int unsigned LONG_CYCLES     = ms_to_cycles(CYCLES_PER_SECOND, LONG_MS);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_timing
        $error("key_input_ctl: need DEBOUNCE_CYCLES >= 1 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    logic ks;

    sync_2ff #(.RESET_VALUE(1'b0)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ACTIVE_HIGH ? key : ~key),
        .q_o (ks)
    );

    logic [1:0]        state_q,         state_d;
    logic [DB_W-1:0]   db_cnt_q,        db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q,      hold_cnt_d;
    logic              long_done_q,     long_done_d;
    logic              key_level_q,     key_level_d;
    logic              press_pulse_q,   press_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic              short_press_q,   short_press_d;
    logic              long_press_q,    long_press_d;
    logic              dir_q,           dir_d;
    logic [3:0]        press_cnt_q,     press_cnt_d;

    // NOTE: every next-state signal gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d         = state_q;
        db_cnt_d        = db_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        long_done_d     = long_done_q;
        key_level_d     = key_level_q;
        dir_d           = dir_q;
        press_cnt_d     = press_cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        short_press_d   = 1'b0;
        long_press_d    = 1'b0;

        // Hold time keeps running through a release bounce so a long press
        // can still mature while the contact chatters.
        if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
            if (hold_cnt_q != HOLD_LAST) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end else if (!long_done_q) begin
                long_press_d = 1'b1;
                dir_d        = ~dir_q;
                long_done_d  = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (ks) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!ks) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d       = PRESSED;
                    hold_cnt_d    = '0;
                    long_done_d   = 1'b0;
                    key_level_d   = 1'b1;
                    press_pulse_d = 1'b1;
                    press_cnt_d   = press_cnt_q + 4'd1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!ks) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = '0;
                end
            end
            default: begin
                if (ks) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d         = IDLE;
                    key_level_d     = 1'b0;
                    release_pulse_d = 1'b1;
                    // A long press maturing on this very cycle also disqualifies short.
                    short_press_d   = ~long_done_d;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            db_cnt_q        <= '0;
            hold_cnt_q      <= '0;
            long_done_q     <= 1'b0;
            key_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            short_press_q   <= 1'b0;
            long_press_q    <= 1'b0;
            dir_q           <= 1'b0;
            press_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            long_done_q     <= long_done_d;
            key_level_q     <= key_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            short_press_q   <= short_press_d;
            long_press_q    <= long_press_d;
            dir_q           <= dir_d;
            press_cnt_q     <= press_cnt_d;
        end
    end

    assign key_level     = key_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign short_press   = short_press_q;
    assign long_press    = long_press_q;
    assign dir           = dir_q;
    assign press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_key_input_ctl.sv
// Self-checking bench for key_input_ctl at 4-cycle debounce / 20-cycle long press.
// Expected strobes are queued with their cycle number and matched as they appear.
module tb_key_input_ctl;

    typedef enum int {EV_PRESS, EV_LONG, EV_REL_SHORT, EV_REL_LONG} ev_e;

    typedef struct {
        ev_e kind;
        int  cyc;
    } exp_ev_t;

    // Key waveform: high hi0, low lo0, high hi1, then low. Event offsets are in
    // clock edges after the key first goes high; -1 means no such event.
    typedef struct {
        string name;
        int    hi0;
        int    lo0;
        int    hi1;
        int    ev_press;
        int    ev_long;
        int    ev_rel;
        bit    ev_short;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_press;
    logic       long_press;
    logic       dir;
    logic [3:0] press_cnt;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         short_seen = 0;
    exp_ev_t    exp_q[$];
    logic [3:0] exp_cnt = 4'd0;
    bit         exp_dir = 1'b0;

    key_input_ctl #(
        .CYCLES_PER_SECOND (1000),
        .DEBOUNCE_MS       (4),
        .LONG_MS           (20),
        .ACTIVE_HIGH       (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key           (key),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .dir           (dir),
        .press_cnt     (press_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic observe(input ev_e kind);
        exp_ev_t e;
        if (exp_q.size() == 0) begin
            check(1'b0, "unexpected strobe", int'(kind), -1);
        end else begin
            e = exp_q.pop_front();
            check(e.kind == kind, "strobe kind", int'(kind), int'(e.kind));
            check(e.cyc == cyc, "strobe cycle", cyc, e.cyc);
        end
    endtask

    // One clock: sample strobes on the falling edge and score them.
    task automatic tick();
        @(negedge clk);
        if (press_pulse && release_pulse)
            check(1'b0, "press and release coincide", 1, 0);
        if (short_press && !release_pulse)
            check(1'b0, "short_press without release_pulse", 1, 0);
        if (press_pulse) observe(EV_PRESS);
        if (long_press) observe(EV_LONG);
        if (release_pulse) begin
            observe(short_press ? EV_REL_SHORT : EV_REL_LONG);
            if (short_press) short_seen++;
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            check(1'b0, "missed strobe", -1, int'(exp_q[0].kind));
            void'(exp_q.pop_front());
        end
    endtask

    task automatic check_all_zero(input string name);
        check({key_level, press_pulse, release_pulse, short_press, long_press, dir, press_cnt} == 10'd0,
              name, int'({key_level, press_pulse, release_pulse, short_press, long_press, dir, press_cnt}), 0);
    endtask

    task automatic push_ev(input ev_e kind, input int at);
        exp_ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic apply_vec(input vec_t v);
        int start;
        bit lvl_exp;
        tick();
        start = cyc;
        if (v.ev_press >= 0) begin
            push_ev(EV_PRESS, start + v.ev_press);
            exp_cnt = exp_cnt + 4'd1;
        end
        if (v.ev_long >= 0) begin
            push_ev(EV_LONG, start + v.ev_long);
            exp_dir = ~exp_dir;
        end
        if (v.ev_rel >= 0)
            push_ev(v.ev_short ? EV_REL_SHORT : EV_REL_LONG, start + v.ev_rel);
        key = 1'b1;
        repeat (v.hi0) tick();
        lvl_exp = (v.ev_press >= 0) && (v.ev_press <= v.hi0);
        check(key_level == lvl_exp, {v.name, " key_level while held"}, int'(key_level), int'(lvl_exp));
        if (v.lo0 > 0) begin
            key = 1'b0;
            repeat (v.lo0) tick();
            key = 1'b1;
            repeat (v.hi1) tick();
        end
        key = 1'b0;
        repeat (25) tick();
        check(key_level == 1'b0, {v.name, " key_level after"}, int'(key_level), 0);
        check(press_cnt == exp_cnt, {v.name, " press_cnt"}, int'(press_cnt), int'(exp_cnt));
        check(dir == exp_dir, {v.name, " dir"}, int'(dir), int'(exp_dir));
    endtask

    initial begin
        vec_t vecs[6];
        vec_t short6;
        int   short_before;
        int   start;

        vecs[0] = '{"clean 10",       10, 0, 0,  7, -1, 17, 1'b1};
        vecs[1] = '{"bounce 3/2/3",    3, 2, 3, -1, -1, -1, 1'b0};
        vecs[2] = '{"glitch 4",        4, 0, 0, -1, -1, -1, 1'b0};
        vecs[3] = '{"minimal 5",       5, 0, 0,  7, -1, 12, 1'b1};
        vecs[4] = '{"long 30",        30, 0, 0,  7, 27, 37, 1'b0};
        vecs[5] = '{"release bounce", 12, 2, 5,  7, -1, 26, 1'b1};
        short6  = '{"short 6",         6, 0, 0,  7, -1, 13, 1'b1};

        rst = 1'b0;
        key = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("outputs in reset");
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("outputs after reset");

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Sixteen presses bring the 4-bit counter all the way round.
        short_before = short_seen;
        for (int i = 0; i < 16; i++) apply_vec(short6);
        check(short_seen - short_before == 16, "short_press strobes over 16 presses", short_seen - short_before, 16);
        check(press_cnt == 4'd4, "press_cnt after wrap", int'(press_cnt), 4);
        check(dir == 1'b1, "dir unchanged by short presses", int'(dir), 1);

        // Reset in the middle of a held press, then a fresh detection afterwards.
        tick();
        start = cyc;
        push_ev(EV_PRESS, start + 7);
        push_ev(EV_PRESS, start + 19);
        push_ev(EV_REL_SHORT, start + 32);
        key = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check_all_zero("outputs at mid-press reset");
        exp_cnt = 4'd1;
        exp_dir = 1'b0;
        repeat (2) tick();
        check_all_zero("outputs held in reset");
        rst = 1'b1;
        repeat (13) tick();
        check(key_level == 1'b1, "key_level after re-detect", int'(key_level), 1);
        key = 1'b0;
        repeat (25) tick();
        check(press_cnt == exp_cnt, "press_cnt after reset re-detect", int'(press_cnt), int'(exp_cnt));
        check(dir == exp_dir, "dir after reset", int'(dir), int'(exp_dir));
        check(exp_q.size() == 0, "scoreboard drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
